// File: rtl/vend_dispense_if.sv
// vend_dispense_if: handshake/data bundle between the top controller (master) and the dispenser (slave).
// Rev 1.0
`default_nettype none

interface vend_dispense_if #(
  parameter int N_ITEMS = 8,
  parameter int KW      = 4,
  parameter int CW      = 6
);
  logic                   enable;
  logic [KW-1:0]          key_code;
  logic                   key_rdy;
  logic [CW-1:0]          credit;
  logic [N_ITEMS*CW-1:0]  price_tbl;
  logic [N_ITEMS-1:0]     sold_out;
  logic [KW-1:0]          item_code;
  logic                   dispencing;
  logic                   done;
  logic                   failed;
  logic                   down_5;
  logic                   down_10;
  logic                   down_25;
  logic                   chg_5;
  logic                   chg_10;
  logic                   chg_25;

  modport master (
    output enable, key_code, key_rdy, credit, price_tbl, sold_out,
    input  item_code, dispencing, done, failed,
    input  down_5, down_10, down_25, chg_5, chg_10, chg_25
  );

  modport slave (
    input  enable, key_code, key_rdy, credit, price_tbl, sold_out,
    output item_code, dispencing, done, failed,
    output down_5, down_10, down_25, chg_5, chg_10, chg_25
  );
endinterface

`default_nettype wire

// File: rtl/vend_dispense.sv
// vend_dispense: price/stock check, greedy one-hot coin-deduct strobes, timed dispense hold.
// Optional change return via CHANGE_RETURN_EN.  Rev 1.0
`default_nettype none

module vend_dispense #(
  parameter int N_ITEMS     = 8,
  parameter int KW          = 4,
  parameter int CW          = 6,
  parameter int WAIT_CYCLES = 2000,
  parameter int TW          = 11
) (
  input  logic            clk,
  input  logic            reset,
  vend_dispense_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAITKEY = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_CHARGE  = 3'd3;
  localparam logic [2:0] S_CHANGE  = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_FAIL    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] key_l_q, key_l_d;
  logic [KW-1:0] item_code_q, item_code_d;
  logic [CW-1:0] credit_l_q, credit_l_d;
  logic [CW-1:0] cost_q, cost_d;
  logic [TW-1:0] timer_q, timer_d;
`ifdef CHANGE_RETURN_EN
  logic [CW-1:0] chg_q, chg_d;
`endif

  logic [CW-1:0] price_sel;
  logic          sold_sel;
  logic          key_ok;

  // Largest coin first: 25c = 5 units, 10c = 2 units, 5c = 1 unit.
  function automatic logic [CW-1:0] greedy_step(input logic [CW-1:0] v);
    if (v >= CW'(5))      return CW'(5);
    else if (v >= CW'(2)) return CW'(2);
    else if (v >= CW'(1)) return CW'(1);
    else                  return '0;
  endfunction

  // Key 1..N_ITEMS selects table entry key-1; any other key leaves key_ok low.
  always_comb begin
    price_sel = '0;
    sold_sel  = 1'b0;
    key_ok    = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (key_l_q == KW'(i + 1)) begin
        price_sel = bus.price_tbl[i*CW +: CW];
        sold_sel  = bus.sold_out[i];
        key_ok    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_l_d     = key_l_q;
    item_code_d = item_code_q;
    credit_l_d  = credit_l_q;
    cost_d      = cost_q;
    timer_d     = timer_q;
`ifdef CHANGE_RETURN_EN
    chg_d       = chg_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_WAITKEY;
      S_WAITKEY: begin
        if (bus.key_rdy) begin
          key_l_d    = bus.key_code;
          credit_l_d = bus.credit;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!key_ok || sold_sel || (price_sel > credit_l_q)) begin
          item_code_d = '0;
          state_d     = S_FAIL;
        end else begin
          item_code_d = key_l_q;
          cost_d      = price_sel;
`ifdef CHANGE_RETURN_EN
          chg_d       = credit_l_q - price_sel;
`endif
          state_d     = S_CHARGE;
        end
      end
      S_CHARGE: begin
        if (cost_q == '0) begin
`ifdef CHANGE_RETURN_EN
          state_d = S_CHANGE;
`else
          state_d = S_HOLD;
`endif
        end else begin
          cost_d = cost_q - greedy_step(cost_q);
        end
      end
`ifdef CHANGE_RETURN_EN
      S_CHANGE: begin
        if (chg_q == '0) state_d = S_HOLD;
        else             chg_d   = chg_q - greedy_step(chg_q);
      end
`endif
      S_HOLD: begin
        if (timer_q == TW'(WAIT_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition, including a same-edge key_rdy.
    if (!bus.enable) begin
      state_d = S_IDLE;
      cost_d  = '0;
      timer_d = '0;
`ifdef CHANGE_RETURN_EN
      chg_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      key_l_q     <= '0;
      item_code_q <= '0;
      credit_l_q  <= '0;
      cost_q      <= '0;
      timer_q     <= '0;
`ifdef CHANGE_RETURN_EN
      chg_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      key_l_q     <= key_l_d;
      item_code_q <= item_code_d;
      credit_l_q  <= credit_l_d;
      cost_q      <= cost_d;
      timer_q     <= timer_d;
`ifdef CHANGE_RETURN_EN
      chg_q       <= chg_d;
`endif
    end
  end

  assign bus.item_code  = item_code_q;
  assign bus.dispencing = (state_q == S_CHARGE) || (state_q == S_CHANGE) ||
                          (state_q == S_HOLD)   || (state_q == S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.failed     = (state_q == S_FAIL);

  assign bus.down_25 = (state_q == S_CHARGE) && (cost_q >= CW'(5));
  assign bus.down_10 = (state_q == S_CHARGE) && (cost_q >= CW'(2)) && (cost_q < CW'(5));
  assign bus.down_5  = (state_q == S_CHARGE) && (cost_q == CW'(1));

`ifdef CHANGE_RETURN_EN
  assign bus.chg_25 = (state_q == S_CHANGE) && (chg_q >= CW'(5));
  assign bus.chg_10 = (state_q == S_CHANGE) && (chg_q >= CW'(2)) && (chg_q < CW'(5));
  assign bus.chg_5  = (state_q == S_CHANGE) && (chg_q == CW'(1));
`else
  assign bus.chg_25 = 1'b0;
  assign bus.chg_10 = 1'b0;
  assign bus.chg_5  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vend_dispense.sv
// tb_vend_dispense: directed vectors for vend_dispense with WAIT_CYCLES=8.
// Rev 1.0
`default_nettype none

module tb_vend_dispense;
  localparam int N_ITEMS = 8;
  localparam int KW      = 4;
  localparam int CW      = 6;
  localparam int WAITC   = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  vend_dispense_if #(.N_ITEMS(N_ITEMS), .KW(KW), .CW(CW)) bif ();

  vend_dispense #(
    .N_ITEMS(N_ITEMS), .KW(KW), .CW(CW), .WAIT_CYCLES(WAITC), .TW(11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {down_25, down_10, down_5, chg_25, chg_10, chg_5}
  function automatic logic [31:0] strb();
    return {26'd0, bif.down_25, bif.down_10, bif.down_5, bif.chg_25, bif.chg_10, bif.chg_5};
  endfunction

  function automatic logic [31:0] all_out();
    return {15'd0, bif.item_code, bif.dispencing, bif.done, bif.failed, 6'd0,
            bif.down_25, bif.down_10, bif.down_5, bif.chg_25, bif.chg_10, bif.chg_5};
  endfunction

  // From IDLE: enable, present key with credit; returns with the DUT in CHECK.
  task automatic start(input logic [KW-1:0] key, input logic [CW-1:0] cr);
    bif.enable = 1'b1;
    step();
    bif.key_code = key;
    bif.credit   = cr;
    bif.key_rdy  = 1'b1;
    step();
    bif.key_rdy  = 1'b0;
    bif.credit   = '0;
  endtask

  task automatic abort();
    bif.enable = 1'b0;
    step();
  endtask

  task automatic expect_fail(input string tag, input logic [KW-1:0] key, input logic [CW-1:0] cr);
    start(key, cr);
    step();
    chk({tag, "_failed"}, {31'd0, bif.failed}, 32'd1);
    chk({tag, "_item"}, {28'd0, bif.item_code}, 32'd0);
    chk({tag, "_strb"}, strb(), 32'd0);
    chk({tag, "_disp"}, {31'd0, bif.dispencing}, 32'd0);
    step();
    chk({tag, "_strb2"}, strb(), 32'd0);
    chk({tag, "_failhold"}, {31'd0, bif.failed}, 32'd1);
    abort();
  endtask

  logic [5:0] seq2 [5] = '{6'b100000, 6'b100000, 6'b010000, 6'b001000, 6'b000000};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bif.enable    = 1'b0;
    bif.key_code  = '0;
    bif.key_rdy   = 1'b0;
    bif.credit    = '0;
    bif.sold_out  = '0;
    bif.price_tbl = '0;
    bif.price_tbl[0*CW +: CW] = 6'd15;
    bif.price_tbl[1*CW +: CW] = 6'd13;
    bif.price_tbl[2*CW +: CW] = 6'd0;
    bif.price_tbl[3*CW +: CW] = 6'd4;
    step();
    chk("reset_outputs", all_out(), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_outputs", all_out(), 32'd0);

    // Item 1, price 15, credit 20: three down_25, then timed hold.
    start(4'd1, 6'd20);
    chk("t1_check_disp", {31'd0, bif.dispencing}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_down25", strb(), 32'b100000);
      chk("t1_disp", {31'd0, bif.dispencing}, 32'd1);
      chk("t1_item", {28'd0, bif.item_code}, 32'd1);
    end
    step();
    chk("t1_charge_end", strb(), 32'd0);
`ifdef CHANGE_RETURN_EN
    step();
    chk("t1_chg25", strb(), 32'b000100);
    step();
    chk("t1_change_end", strb(), 32'd0);
`endif
    step();
    for (int i = 1; i < WAITC; i++) begin
      step();
      chk("t1_hold_notdone", {31'd0, bif.done}, 32'd0);
    end
    step();
    chk("t1_done", {31'd0, bif.done}, 32'd1);
    chk("t1_done_disp", {31'd0, bif.dispencing}, 32'd1);
    abort();
    chk("t1_abort_disp", {31'd0, bif.dispencing}, 32'd0);
    chk("t1_abort_done", {31'd0, bif.done}, 32'd0);
    chk("t1_item_kept", {28'd0, bif.item_code}, 32'd1);

    // Item 2, price 13, credit 13: 25,25,10,5; then abort mid-hold.
    start(4'd2, 6'd13);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_seq", strb(), {26'd0, seq2[i]});
      chk("t2_onehot", {31'd0, $countones(strb()) <= 1}, 32'd1);
    end
`ifdef CHANGE_RETURN_EN
    step();
    chk("t2_change_zero", strb(), 32'd0);
`endif
    step();
    chk("t2_hold_disp", {31'd0, bif.dispencing}, 32'd1);
    step();
    step();
    abort();
    chk("t2_abort_disp", {31'd0, bif.dispencing}, 32'd0);
    for (int i = 0; i < WAITC + 2; i++) begin
      step();
      chk("t2_never_done", {31'd0, bif.done}, 32'd0);
    end

    expect_fail("t3_short", 4'd2, 6'd10);
    expect_fail("t3_key0", 4'd0, 6'd63);
    expect_fail("t3_key9", 4'd9, 6'd63);
    bif.sold_out = 8'b0000_1000;
    expect_fail("t4_soldout", 4'd4, 6'd63);
    bif.sold_out = '0;

    // Price 0: one CHARGE cycle without strobes.
    start(4'd3, 6'd0);
    step();
    chk("t5_p0_strb", strb(), 32'd0);
    chk("t5_p0_disp", {31'd0, bif.dispencing}, 32'd1);
    chk("t5_p0_item", {28'd0, bif.item_code}, 32'd3);
    step();
    chk("t5_p0_next", strb(), 32'd0);
    chk("t5_p0_disp2", {31'd0, bif.dispencing}, 32'd1);
    abort();

`ifdef CHANGE_RETURN_EN
    // Price 13, credit 20: charge as above, then 7 units change as 25c + 10c.
    start(4'd2, 6'd20);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_down", strb(), {26'd0, seq2[i]});
    end
    step();
    chk("t6_chg25", strb(), 32'b000100);
    step();
    chk("t6_chg10", strb(), 32'b000010);
    step();
    chk("t6_chg_end", strb(), 32'd0);
    step();
    chk("t6_hold", strb(), 32'd0);
    chk("t6_hold_disp", {31'd0, bif.dispencing}, 32'd1);
    abort();
`endif

    // Asynchronous reset in the middle of CHARGE.
    start(4'd1, 6'd20);
    step();
    chk("t7_charging", strb(), 32'b100000);
    #2;
    reset = 1'b0;
    #1;
    chk("t7_async_reset", all_out(), 32'd0);
    bif.enable = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("t7_after_reset", all_out(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
